// File: rtl/scr_update_gen.sv
// scr_update_gen
//   Sender side of the scrambler-config update interface. Firmware offers a
//   {scr_choose, unscr_length} pair over wr_valid/wr_ready. The pair is
//   registered onto the config outputs at the accept edge. A timed
//   update_flag sequence then follows: SETUP (flag low), PULSE (flag high),
//   GAP (flag low). The receiver double-flops update_flag and latches the
//   config on its rising edge.
//
//   Optional feature macro: SCR_UPD_ACK_EN. When it is defined, an upd_ack
//   input from the receiver domain is added. PULSE additionally waits for the
//   synced ack to be high, and GAP waits for it to be low. There is no timeout.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   wr_valid/wr_ready     write handshake (wr_ready = state IDLE)
//   wr_scr_choose         requested scrambler select
//   wr_unscr_length[7:0]  requested length, clamped to LEN_MAX
//   scr_choose_out        registered config to receiver
//   unscr_length_out[7:0] registered config to receiver
//   update_flag           registered update strobe
//   busy                  sequence in progress (= !wr_ready)
//   upd_done              1-cycle pulse when the sequence completes
//   len_err               1-cycle pulse after an accept whose length was clamped
//   upd_ack               (SCR_UPD_ACK_EN only) receiver acknowledge, level

module scr_update_gen #(
    parameter int SETUP_CYCLES = 2,
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 4,
    parameter int LEN_MAX      = 200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       wr_scr_choose,
    input  logic [7:0] wr_unscr_length,
    output logic       scr_choose_out,
    output logic [7:0] unscr_length_out,
    output logic       update_flag,
    output logic       busy,
    output logic       upd_done,
`ifdef SCR_UPD_ACK_EN
    input  logic       upd_ack,
`endif
    output logic       len_err
);

    localparam int MAX_SP = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int MAX_P  = (MAX_SP > GAP_CYCLES) ? MAX_SP : GAP_CYCLES;
    localparam int CNT_W  = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [7:0]       LEN_MAX_V = 8'(LEN_MAX);

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, GAP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             scr_q, scr_d;
    logic [7:0]       len_q, len_d;
    logic             flag_q, flag_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // Exit qualifiers for PULSE and GAP. Without the ack feature they are
    // always true, so only the minimum-time counters govern the sequence.
    logic             pulse_exit_ok, gap_exit_ok;

`ifdef SCR_UPD_ACK_EN
    logic ack_meta_q, ack_sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_meta_q <= 1'b0;
            ack_sync_q <= 1'b0;
        end else begin
            ack_meta_q <= upd_ack;
            ack_sync_q <= ack_meta_q;
        end
    end

    assign pulse_exit_ok = ack_sync_q;
    assign gap_exit_ok   = !ack_sync_q;
`else
    assign pulse_exit_ok = 1'b1;
    assign gap_exit_ok   = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        scr_d   = scr_q;
        len_d   = len_q;
        flag_d  = flag_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_valid) begin
                    scr_d   = wr_scr_choose;
                    len_d   = (wr_unscr_length > LEN_MAX_V) ? LEN_MAX_V : wr_unscr_length;
                    err_d   = (wr_unscr_length > LEN_MAX_V);
                    cnt_d   = SETUP_LD;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = PULSE;
                    cnt_d   = PULSE_LD;
                    flag_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            // The counter parks at zero while waiting on the exit qualifier,
            // so it never wraps inside a state.
            PULSE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (pulse_exit_ok) begin
                    state_d = GAP;
                    cnt_d   = GAP_LD;
                    flag_d  = 1'b0;
                end
            end
            GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (gap_exit_ok) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            scr_q   <= 1'b0;
            len_q   <= '0;
            flag_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            scr_q   <= scr_d;
            len_q   <= len_d;
            flag_q  <= flag_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign wr_ready         = (state_q == IDLE);
    assign busy             = !wr_ready;
    assign scr_choose_out   = scr_q;
    assign unscr_length_out = len_q;
    assign update_flag      = flag_q;
    assign upd_done         = done_q;
    assign len_err          = err_q;

endmodule

// File: tb/tb_scr_update_gen.sv
// Directed bench for scr_update_gen (default parameters 2/4/4/200).
// Inputs change and outputs are sampled 2 time units after each rising edge.
// "k" is the number of rising edges since the accept edge (k=0 is the cycle
// right after the accept edge).

module tb_scr_update_gen;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_valid;
    logic       wr_ready;
    logic       wr_scr_choose;
    logic [7:0] wr_unscr_length;
    logic       scr_choose_out;
    logic [7:0] unscr_length_out;
    logic       update_flag;
    logic       busy;
    logic       upd_done;
    logic       len_err;
`ifdef SCR_UPD_ACK_EN
    logic       upd_ack;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    scr_update_gen dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .wr_valid         (wr_valid),
        .wr_ready         (wr_ready),
        .wr_scr_choose    (wr_scr_choose),
        .wr_unscr_length  (wr_unscr_length),
        .scr_choose_out   (scr_choose_out),
        .unscr_length_out (unscr_length_out),
        .update_flag      (update_flag),
        .busy             (busy),
        .upd_done         (upd_done),
`ifdef SCR_UPD_ACK_EN
        .upd_ack          (upd_ack),
`endif
        .len_err          (len_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Check every output against expected values.
    task automatic chk_outs(input string tag, input int k, input logic e_flag,
                            input logic e_done, input logic e_busy, input logic e_scr,
                            input logic [7:0] e_len, input logic e_err);
        string t;
        t = $sformatf("%s k=%0d", tag, k);
        chk({t, " update_flag"}, 32'(update_flag), 32'(e_flag));
        chk({t, " upd_done"},    32'(upd_done),    32'(e_done));
        chk({t, " busy"},        32'(busy),        32'(e_busy));
        chk({t, " wr_ready"},    32'(wr_ready),    32'(!e_busy));
        chk({t, " scr_choose"},  32'(scr_choose_out), 32'(e_scr));
        chk({t, " unscr_len"},   32'(unscr_length_out), 32'(e_len));
        chk({t, " len_err"},     32'(len_err),     32'(e_err));
    endtask

    // Called in the k=0 cycle; walks the fixed-timing sequence to upd_done.
    task automatic seq_check(input string tag, input logic e_scr,
                             input logic [7:0] e_len, input logic e_err);
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) step();
            chk_outs(tag, k, (k >= 2 && k <= 5), (k == 10), (k < 10),
                     e_scr, e_len, e_err && (k == 0));
        end
    endtask

    task automatic do_write(input string tag, input logic scr, input logic [7:0] len,
                            input logic [7:0] e_len, input logic e_err);
        wr_valid        = 1'b1;
        wr_scr_choose   = scr;
        wr_unscr_length = len;
        step();
        wr_valid = 1'b0;
        seq_check(tag, scr, e_len, e_err);
    endtask

    initial begin
        reset_n         = 1'b0;
        wr_valid        = 1'b0;
        wr_scr_choose   = 1'b0;
        wr_unscr_length = 8'h00;
`ifdef SCR_UPD_ACK_EN
        upd_ack         = 1'b0;
`endif
        step();
        chk_outs("in_reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step();
        reset_n = 1'b1;

        // 1: idle after reset, nothing offered
        for (int i = 0; i < 6; i++) begin
            step();
            chk_outs("idle", i, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        end

`ifndef SCR_UPD_ACK_EN
        // 2: basic write
        do_write("wr40", 1'b1, 8'h40, 8'h40, 1'b0);
        step();
        chk_outs("wr40_after", 11, 1'b0, 1'b0, 1'b0, 1'b1, 8'h40, 1'b0);

        // 3: clamped length, and boundary at exactly LEN_MAX
        do_write("wrFF", 1'b0, 8'hFF, 8'hC8, 1'b1);
        do_write("wrC9", 1'b1, 8'hC9, 8'hC8, 1'b1);
        do_write("wrC8", 1'b0, 8'hC8, 8'hC8, 1'b0);

        // 4: offer held during busy; accept only after the upd_done cycle,
        //    then back-to-back sequence
        wr_valid        = 1'b1;
        wr_scr_choose   = 1'b1;
        wr_unscr_length = 8'h20;
        step();
        wr_scr_choose   = 1'b0;
        wr_unscr_length = 8'h10;
        seq_check("held_a", 1'b1, 8'h20, 1'b0);
        step();
        wr_valid = 1'b0;
        seq_check("held_b", 1'b0, 8'h10, 1'b0);

        // 5: reset during PULSE drops outputs without a clock edge
        wr_valid        = 1'b1;
        wr_scr_choose   = 1'b1;
        wr_unscr_length = 8'h55;
        step();
        wr_valid = 1'b0;
        step(); step(); step();
        chk("rst_pre update_flag", 32'(update_flag), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk_outs("rst_async", 3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step();
        reset_n = 1'b1;
        step();
        chk_outs("rst_rel", 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        do_write("post_rst", 1'b1, 8'h07, 8'h07, 1'b0);
`else
        // 6: ack handshake; ack raised 10 cycles after the flag rises and
        //    dropped at k=20. Two sync flops plus one edge to leave each state.
        wr_valid        = 1'b1;
        wr_scr_choose   = 1'b1;
        wr_unscr_length = 8'h40;
        step();
        wr_valid = 1'b0;
        for (int k = 0; k <= 24; k++) begin
            if (k > 0) step();
            chk_outs("ack", k, (k >= 2 && k <= 14), (k == 23), (k < 23),
                     1'b1, 8'h40, 1'b0);
            if (k == 12) upd_ack = 1'b1;
            if (k == 20) upd_ack = 1'b0;
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
